// File: rtl/ds2_pkg.sv
// Shared types and constants for the DS2 device-side protocol engine.
package ds2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StAckWait,
    StAckPulse,
    StHold
  } ds2_state_e;

  // Host command bytes (command byte 1)
  localparam logic [7:0] CmdStart  = 8'h01;
  localparam logic [7:0] CmdPoll   = 8'h42;
  localparam logic [7:0] CmdConfig = 8'h43;
  localparam logic [7:0] CmdMode   = 8'h44;

  // Device ID bytes (response byte 1)
  localparam logic [7:0] IdDigital = 8'h41;
  localparam logic [7:0] IdAnalog  = 8'h73;
  localparam logic [7:0] IdConfig  = 8'hF3;

  localparam logic [7:0] HdrByte = 8'h5A;

  localparam logic [3:0] LenDigital = 4'd5;
  localparam logic [3:0] LenAnalog  = 4'd9;

  // Response byte for a given frame position; sticks packed {ly, lx, ry, rx}.
  function automatic logic [7:0] resp_byte(input logic [3:0]  idx,
                                           input logic [7:0]  id,
                                           input logic        zero_data,
                                           input logic [15:0] btn_n,
                                           input logic [31:0] sticks);
    logic [7:0] b;
    case (idx)
      4'd0:    b = 8'hFF;
      4'd1:    b = id;
      4'd2:    b = HdrByte;
      4'd3:    b = btn_n[7:0];
      4'd4:    b = btn_n[15:8];
      4'd5:    b = sticks[7:0];
      4'd6:    b = sticks[15:8];
      4'd7:    b = sticks[23:16];
      4'd8:    b = sticks[31:24];
      default: b = 8'hFF;
    endcase
    if (zero_data && idx >= 4'd3 && idx <= 4'd8) b = 8'h00;
    return b;
  endfunction

endpackage

// File: rtl/ds2_sync.sv
// Two-flop synchronizer with edge detect on the synchronized value.
module ds2_sync (
  input  logic clk,
  input  logic din,
  output logic q,
  output logic rise,
  output logic fall
);

  // [0],[1] synchronize, [2] holds the previous synchronized value.
  logic [2:0] sync_q;

  // Not reset on purpose: the chain keeps tracking the pin during rst so no
  // phantom edge appears when rst is released with the input already low.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[1:0], din};
  end

  assign q    = sync_q[1];
  assign rise = sync_q[1] & ~sync_q[2];
  assign fall = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ds2_device.sv
// DS2 (PlayStation 2 controller) device-side protocol engine.
// Optional config-mode support (commands 0x43/0x44) compiled in by defining
// DS2_DEVICE_CONFIG_EN; without it the mode follows the analog pin at ATT fall.
module ds2_device #(
  parameter int unsigned ACK_DELAY = 40,
  parameter int unsigned ACK_WIDTH = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ds2_att,
  input  logic        ds2_clk,
  input  logic        ds2_cmd,
  output logic        ds2_dat,
  output logic        ds2_ack,
  input  logic        analog,
  input  logic [15:0] buttons,
  input  logic [7:0]  stick_rx,
  input  logic [7:0]  stick_ry,
  input  logic [7:0]  stick_lx,
  input  logic [7:0]  stick_ly,
  output logic [7:0]  rumble_small,
  output logic [7:0]  rumble_large,
  output logic        frame_done
);
  import ds2_pkg::*;

  logic att_s, att_rise, att_fall;
  logic sclk_s, clk_rise, clk_fall;
  logic cmd_s, cmd_rise, cmd_fall;

  ds2_sync u_sync_att (.clk(clk), .din(ds2_att), .q(att_s),  .rise(att_rise), .fall(att_fall));
  ds2_sync u_sync_clk (.clk(clk), .din(ds2_clk), .q(sclk_s), .rise(clk_rise), .fall(clk_fall));
  ds2_sync u_sync_cmd (.clk(clk), .din(ds2_cmd), .q(cmd_s),  .rise(cmd_rise), .fall(cmd_fall));

  logic unused_sync;
  assign unused_sync = att_s ^ sclk_s ^ cmd_rise ^ cmd_fall;

  ds2_state_e  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  tx_q, tx_d, rx_q, rx_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dat_q, dat_d, ack_q, ack_d, done_q, done_d;
  logic [7:0]  cmd1_q, cmd1_d, cmd3_q, cmd3_d, cmd4_q, cmd4_d;
  logic [7:0]  rumble_small_q, rumble_small_d, rumble_large_q, rumble_large_d;
  logic [15:0] snap_btn_n_q, snap_btn_n_d;
  logic [31:0] snap_sticks_q, snap_sticks_d;
  logic        snap_analog_q, snap_analog_d, snap_cfg_q, snap_cfg_d;
`ifdef DS2_DEVICE_CONFIG_EN
  logic        cfg_q, cfg_d, mode_q, mode_d;
`endif

  logic [7:0] id_byte, resp_next, byte_val;
  logic [3:0] frame_len;
  logic       clk_edge;

  assign id_byte   = snap_cfg_q ? IdConfig : (snap_analog_q ? IdAnalog : IdDigital);
  assign frame_len = (snap_cfg_q | snap_analog_q) ? LenAnalog : LenDigital;
  assign resp_next = resp_byte(byte_idx_q + 4'd1, id_byte, snap_cfg_q, snap_btn_n_q,
                               snap_sticks_q);
  assign byte_val  = {cmd_s, rx_q[7:1]};
  assign clk_edge  = clk_rise | clk_fall;

  // Next-state: FSM, bit/byte shifting, ACK timing and end-of-frame updates.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    byte_idx_d     = byte_idx_q;
    tx_d           = tx_q;
    rx_d           = rx_q;
    cnt_d          = cnt_q;
    dat_d          = dat_q;
    ack_d          = ack_q;
    done_d         = 1'b0;
    cmd1_d         = cmd1_q;
    cmd3_d         = cmd3_q;
    cmd4_d         = cmd4_q;
    rumble_small_d = rumble_small_q;
    rumble_large_d = rumble_large_q;
    snap_btn_n_d   = snap_btn_n_q;
    snap_sticks_d  = snap_sticks_q;
    snap_analog_d  = snap_analog_q;
    snap_cfg_d     = snap_cfg_q;
`ifdef DS2_DEVICE_CONFIG_EN
    cfg_d          = cfg_q;
    mode_d         = mode_q;
`endif

    unique case (state_q)
      StIdle: begin
        dat_d = 1'b1;
        ack_d = 1'b1;
        if (att_fall) begin
          state_d       = StShift;
          bit_cnt_d     = '0;
          byte_idx_d    = '0;
          tx_d          = 8'hFF;
          dat_d         = 1'b1;
          cmd1_d        = '0;
          cmd3_d        = '0;
          cmd4_d        = '0;
          snap_btn_n_d  = ~buttons;
          snap_sticks_d = {stick_ly, stick_lx, stick_ry, stick_rx};
`ifdef DS2_DEVICE_CONFIG_EN
          snap_analog_d = mode_q;
          snap_cfg_d    = cfg_q;
`else
          snap_analog_d = analog;
          snap_cfg_d    = 1'b0;
`endif
        end
      end
      StShift, StAckWait, StAckPulse: begin
        // A host clock edge during the ACK phase starts the next byte early.
        if (state_q == StAckWait) begin
          if (clk_edge) begin
            state_d = StShift;
          end else if (cnt_q == 16'(ACK_DELAY - 1)) begin
            state_d = StAckPulse;
            ack_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else if (state_q == StAckPulse) begin
          if (clk_edge || cnt_q == 16'(ACK_WIDTH - 1)) begin
            state_d = StShift;
            ack_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        if (clk_fall) dat_d = tx_q[0];
        if (clk_rise) begin
          rx_d      = byte_val;
          tx_d      = {1'b1, tx_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_idx_q == 4'd1) cmd1_d = byte_val;
            if (byte_idx_q == 4'd3) cmd3_d = byte_val;
            if (byte_idx_q == 4'd4) cmd4_d = byte_val;
            if (byte_idx_q == frame_len - 4'd1) begin
              state_d = StHold;
              dat_d   = 1'b1;
              done_d  = 1'b1;
              if (cmd1_d == CmdPoll) begin
                rumble_small_d = cmd3_d;
                rumble_large_d = cmd4_d;
              end
`ifdef DS2_DEVICE_CONFIG_EN
              if (cmd1_d == CmdConfig) begin
                if (cmd3_d == 8'h01)      cfg_d = 1'b1;
                else if (cmd3_d == 8'h00) cfg_d = 1'b0;
              end
              if (cmd1_d == CmdMode && snap_cfg_q) begin
                if (cmd3_d == 8'h01)      mode_d = 1'b1;
                else if (cmd3_d == 8'h00) mode_d = 1'b0;
              end
`endif
            end else begin
              state_d    = StAckWait;
              byte_idx_d = byte_idx_q + 4'd1;
              tx_d       = resp_next;
              dat_d      = resp_next[0];
              cnt_d      = '0;
            end
          end
        end
      end
      StHold: begin
        dat_d = 1'b1;
        ack_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // ATT release ends any transfer; an unfinished frame leaves no side effects.
    if (state_q != StIdle && att_rise) begin
      state_d        = StIdle;
      dat_d          = 1'b1;
      ack_d          = 1'b1;
      done_d         = 1'b0;
      rumble_small_d = rumble_small_q;
      rumble_large_d = rumble_large_q;
`ifdef DS2_DEVICE_CONFIG_EN
      cfg_d          = cfg_q;
      mode_d         = mode_q;
`endif
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      byte_idx_q     <= '0;
      tx_q           <= 8'hFF;
      rx_q           <= '0;
      cnt_q          <= '0;
      dat_q          <= 1'b1;
      ack_q          <= 1'b1;
      done_q         <= 1'b0;
      cmd1_q         <= '0;
      cmd3_q         <= '0;
      cmd4_q         <= '0;
      rumble_small_q <= '0;
      rumble_large_q <= '0;
      snap_btn_n_q   <= '1;
      snap_sticks_q  <= '0;
      snap_analog_q  <= 1'b0;
      snap_cfg_q     <= 1'b0;
`ifdef DS2_DEVICE_CONFIG_EN
      cfg_q          <= 1'b0;
      mode_q         <= analog;
`endif
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_idx_q     <= byte_idx_d;
      tx_q           <= tx_d;
      rx_q           <= rx_d;
      cnt_q          <= cnt_d;
      dat_q          <= dat_d;
      ack_q          <= ack_d;
      done_q         <= done_d;
      cmd1_q         <= cmd1_d;
      cmd3_q         <= cmd3_d;
      cmd4_q         <= cmd4_d;
      rumble_small_q <= rumble_small_d;
      rumble_large_q <= rumble_large_d;
      snap_btn_n_q   <= snap_btn_n_d;
      snap_sticks_q  <= snap_sticks_d;
      snap_analog_q  <= snap_analog_d;
      snap_cfg_q     <= snap_cfg_d;
`ifdef DS2_DEVICE_CONFIG_EN
      cfg_q          <= cfg_d;
      mode_q         <= mode_d;
`endif
    end
  end

  assign ds2_dat      = dat_q;
  assign ds2_ack      = ack_q;
  assign frame_done   = done_q;
  assign rumble_small = rumble_small_q;
  assign rumble_large = rumble_large_q;

endmodule

// File: tb/tb_ds2_device.sv
// Self-checking bench for ds2_device: host bit-bangs frames at clk/8 and
// compares returned bytes against a scoreboard of model responses.
module tb_ds2_device;

  localparam int AckDelay = 40;
  localparam int AckWidth = 100;
  localparam int HalfBit  = 4;

  logic        clk = 1'b0;
  logic        rst, ds2_att, ds2_clk, ds2_cmd, analog;
  logic        ds2_dat, ds2_ack, frame_done;
  logic [15:0] buttons;
  logic [7:0]  stick_rx, stick_ry, stick_lx, stick_ly;
  logic [7:0]  rumble_small, rumble_large;

  ds2_device #(.ACK_DELAY(AckDelay), .ACK_WIDTH(AckWidth)) dut (
    .clk(clk), .rst(rst), .ds2_att(ds2_att), .ds2_clk(ds2_clk), .ds2_cmd(ds2_cmd),
    .ds2_dat(ds2_dat), .ds2_ack(ds2_ack), .analog(analog), .buttons(buttons),
    .stick_rx(stick_rx), .stick_ry(stick_ry), .stick_lx(stick_lx), .stick_ly(stick_ly),
    .rumble_small(rumble_small), .rumble_large(rumble_large), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         ack_widths[$];
  int         ack_low_len = 0;
  int         done_cnt = 0;
  logic [7:0] cmd_bytes[9];
  bit         m_analog = 1'b0;
  bit         m_cfg = 1'b0;
  logic [7:0] m_rs = 8'h00;
  logic [7:0] m_rl = 8'h00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // ACK pulse widths and frame_done pulses seen on the bus.
  always @(negedge clk) begin
    if (!ds2_ack) ack_low_len++;
    else if (ack_low_len != 0) begin
      ack_widths.push_back(ack_low_len);
      ack_low_len = 0;
    end
    if (frame_done) done_cnt++;
  end

  function automatic logic [7:0] model_byte(input int idx);
    logic [7:0] id;
    id = m_cfg ? 8'hF3 : (m_analog ? 8'h73 : 8'h41);
    if (m_cfg && idx >= 3) return 8'h00;
    case (idx)
      0: return 8'hFF;
      1: return id;
      2: return 8'h5A;
      3: return ~buttons[7:0];
      4: return ~buttons[15:8];
      5: return stick_rx;
      6: return stick_ry;
      7: return stick_lx;
      8: return stick_ly;
      default: return 8'hFF;
    endcase
  endfunction

  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      ds2_clk = 1'b0;
      ds2_cmd = tx[i];
      repeat (HalfBit) @(negedge clk);
      ds2_clk = 1'b1;
      rx[i]   = ds2_dat;
      repeat (HalfBit) @(negedge clk);
    end
  endtask

  task automatic wait_ack(input string name);
    int t;
    t = 0;
    while (ds2_ack && t < AckDelay + 20) begin
      @(negedge clk);
      t++;
    end
    check_eq($sformatf("%s_ack_low", name), ds2_ack, 1'b0);
    t = 0;
    while (!ds2_ack && t < AckWidth + 20) begin
      @(negedge clk);
      t++;
    end
    check_eq($sformatf("%s_ack_rel", name), ds2_ack, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_dat", ds2_dat, 1'b1);
    check_eq("rst_ack", ds2_ack, 1'b1);
    check_eq("rst_rumble_small", rumble_small, 8'h00);
    check_eq("rst_rumble_large", rumble_large, 8'h00);
    check_eq("rst_frame_done", frame_done, 1'b0);
    repeat (2) @(negedge clk);
    m_rs = 8'h00;
    m_rl = 8'h00;
`ifdef DS2_DEVICE_CONFIG_EN
    m_analog = analog;
    m_cfg    = 1'b0;
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // abort_kind: 0 = none, 1 = raise ATT, 2 = assert rst, after abort_bits of abort_byte.
  task automatic run_frame(input string name, input int abort_kind, input int abort_byte,
                           input int abort_bits);
    int         n, done0, lowc, bad;
    logic [7:0] rb, exp;
    bit         cfg_old;
`ifndef DS2_DEVICE_CONFIG_EN
    m_analog = analog;
    m_cfg    = 1'b0;
`endif
    n = (m_analog || m_cfg) ? 9 : 5;
    for (int b = 0; b < n; b++) exp_q.push_back(model_byte(b));
    ack_widths.delete();
    done0   = done_cnt;
    ds2_att = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < n; b++) begin
      if (abort_kind != 0 && b == abort_byte) begin
        xfer_bits(cmd_bytes[b], abort_bits, rb);
        exp_q.delete();
        if (abort_kind == 1) begin
          ds2_att = 1'b1;
          repeat (3) @(negedge clk);
          check_eq($sformatf("%s_abort_dat", name), ds2_dat, 1'b1);
          check_eq($sformatf("%s_abort_ack", name), ds2_ack, 1'b1);
          repeat (20) @(negedge clk);
          check_eq($sformatf("%s_abort_rs", name), rumble_small, m_rs);
          check_eq($sformatf("%s_abort_rl", name), rumble_large, m_rl);
          check_eq($sformatf("%s_abort_done", name), done_cnt - done0, 0);
        end else begin
          apply_reset();
          ds2_att = 1'b1;
          repeat (8) @(negedge clk);
        end
        return;
      end
      xfer_bits(cmd_bytes[b], 8, rb);
      exp = exp_q.pop_front();
      check_eq($sformatf("%s_byte%0d", name, b), rb, exp);
      if (b < n - 1) wait_ack(name);
      else begin
        lowc = 0;
        repeat (AckDelay + AckWidth + 20) begin
          @(negedge clk);
          if (!ds2_ack) lowc++;
        end
        check_eq($sformatf("%s_no_last_ack", name), lowc, 0);
      end
    end
    check_eq($sformatf("%s_ack_count", name), ack_widths.size(), n - 1);
    bad = 0;
    foreach (ack_widths[i]) if (ack_widths[i] != AckWidth) bad++;
    check_eq($sformatf("%s_ack_width_bad", name), bad, 0);
    check_eq($sformatf("%s_done", name), done_cnt - done0, 1);
    ds2_att = 1'b1;
    repeat (8) @(negedge clk);
    cfg_old = m_cfg;
    if (cmd_bytes[1] == 8'h42) begin
      m_rs = cmd_bytes[3];
      m_rl = cmd_bytes[4];
    end
`ifdef DS2_DEVICE_CONFIG_EN
    if (cmd_bytes[1] == 8'h43 && cmd_bytes[3] == 8'h01) m_cfg = 1'b1;
    if (cmd_bytes[1] == 8'h43 && cmd_bytes[3] == 8'h00) m_cfg = 1'b0;
    if (cmd_bytes[1] == 8'h44 && cfg_old && cmd_bytes[3] == 8'h01) m_analog = 1'b1;
    if (cmd_bytes[1] == 8'h44 && cfg_old && cmd_bytes[3] == 8'h00) m_analog = 1'b0;
`endif
    check_eq($sformatf("%s_rumble_small", name), rumble_small, m_rs);
    check_eq($sformatf("%s_rumble_large", name), rumble_large, m_rl);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ds2_att = 1'b1; ds2_clk = 1'b1; ds2_cmd = 1'b1; analog = 1'b0;
    buttons = 16'h0000;
    stick_rx = 8'h00; stick_ry = 8'h00; stick_lx = 8'h00; stick_ly = 8'h00;
    repeat (4) @(negedge clk);
    apply_reset();

    // Digital poll
    buttons   = 16'h0001;
    cmd_bytes = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("dig", 0, 0, 0);

    // Analog poll with rumble
    analog   = 1'b1;
    buttons  = 16'h0000;
    stick_rx = 8'h80; stick_ry = 8'h7F; stick_lx = 8'h00; stick_ly = 8'hFF;
`ifdef DS2_DEVICE_CONFIG_EN
    apply_reset();
`endif
    cmd_bytes = '{8'h01, 8'h42, 8'h00, 8'hAA, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("ana", 0, 0, 0);

    // ATT raised after 2 bits of byte 3, then a normal poll
    cmd_bytes = '{8'h01, 8'h42, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("abort", 1, 3, 2);
    analog    = 1'b0;
    buttons   = 16'h8001;
    cmd_bytes = '{8'h01, 8'h42, 8'h00, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("post_abort", 0, 0, 0);

    // rst mid-byte 2, then a fresh poll
    analog    = 1'b1;
    cmd_bytes = '{8'h01, 8'h42, 8'h00, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("rst_mid", 2, 2, 3);
    buttons   = 16'h0F0F;
    cmd_bytes = '{8'h01, 8'h42, 8'h00, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("post_rst", 0, 0, 0);

`ifdef DS2_DEVICE_CONFIG_EN
    analog  = 1'b0;
    buttons = 16'h0000;
    apply_reset();
    cmd_bytes = '{8'h01, 8'h43, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("cfg_enter", 0, 0, 0);
    cmd_bytes = '{8'h01, 8'h44, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("cfg_mode", 0, 0, 0);
    cmd_bytes = '{8'h01, 8'h43, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("cfg_exit", 0, 0, 0);
    cmd_bytes = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    run_frame("cfg_poll", 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
